// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// A grant covers a whole packet; an owner that stalls too long loses its grant.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int HOLD_TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   input  logic                 tx_done,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 timeout_err,
   output logic [15:0]          pkt_count
);

   // state   | meaning
   // ST_IDLE | no owner; arbitrate among valid requesters from rr_ptr upward
   // ST_SEND | owner holds grant; waiting for its next byte (hold timer runs)
   // ST_WAIT | byte handed to transmitter; waiting for tx_done
   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT} state_t;

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(HOLD_TIMEOUT) + 1;

   state_t             state, state_nxt;
   logic [NUM_REQ-1:0] grant_nxt;
   logic [IW-1:0]      rr_ptr, rr_ptr_nxt;
   logic [CW-1:0]      hold_cnt, hold_cnt_nxt;
   logic               last_flag, last_flag_nxt;
   logic               tx_start_nxt;
   logic [7:0]         tx_data_nxt;
   logic               timeout_err_nxt;
   logic [15:0]        pkt_count_nxt;

   logic [IW-1:0]      owner_idx, owner_inc;
   logic [7:0]         owner_data;
   logic               owner_last;
   logic [IW-1:0]      pick_idx;
   logic               pick_found;
   logic               xfer;

   function automatic logic [IW-1:0] rr_offset(input logic [IW-1:0] base, input int k);
      int p;
      p = int'(base) + k;
      if (p >= NUM_REQ) p = p - NUM_REQ;
      return IW'(p);
   endfunction

   // Owner byte/flag are taken only through the grant bit, so non-owner inputs never reach tx_data.
   always_comb begin
      owner_idx  = '0;
      owner_data = '0;
      owner_last = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            owner_idx  = IW'(i);
            owner_data = req_data[8*i +: 8];
            owner_last = req_last[i];
         end
      end
   end

   assign owner_inc = (owner_idx == IW'(NUM_REQ-1)) ? '0 : owner_idx + 1'b1;

   // Scan downward so the lowest offset from rr_ptr is the final (winning) assignment.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         if (req_valid[rr_offset(rr_ptr, k)]) begin
            pick_found = 1'b1;
            pick_idx   = rr_offset(rr_ptr, k);
         end
      end
   end

   assign req_ready = (state == ST_SEND && !tx_busy) ? grant : '0;
   assign xfer      = |(req_valid & req_ready);

   always_comb begin
      state_nxt       = state;
      grant_nxt       = grant;
      rr_ptr_nxt      = rr_ptr;
      hold_cnt_nxt    = hold_cnt;
      last_flag_nxt   = last_flag;
      tx_start_nxt    = 1'b0;
      tx_data_nxt     = tx_data;
      timeout_err_nxt = 1'b0;
      pkt_count_nxt   = pkt_count;
      case (state)
         ST_IDLE: begin
            hold_cnt_nxt = '0;
            if (pick_found) begin
               grant_nxt = NUM_REQ'(1) << pick_idx;
               state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (xfer) begin
               tx_start_nxt  = 1'b1;
               tx_data_nxt   = owner_data;
               last_flag_nxt = owner_last;
               hold_cnt_nxt  = '0;
               state_nxt     = ST_WAIT;
            end else if (hold_cnt == CW'(HOLD_TIMEOUT-1)) begin
               timeout_err_nxt = 1'b1;
               grant_nxt       = '0;
               rr_ptr_nxt      = owner_inc;
               hold_cnt_nxt    = '0;
               state_nxt       = ST_IDLE;
            end else begin
               hold_cnt_nxt = hold_cnt + 1'b1;
            end
         end
         ST_WAIT: begin
            // A done coincident with our own start pulse belongs to an earlier frame.
            if (tx_done && !tx_start) begin
               if (last_flag) begin
                  pkt_count_nxt = pkt_count + 1'b1;
                  rr_ptr_nxt    = owner_inc;
                  grant_nxt     = '0;
                  state_nxt     = ST_IDLE;
               end else begin
                  state_nxt = ST_SEND;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         grant       <= '0;
         rr_ptr      <= '0;
         hold_cnt    <= '0;
         last_flag   <= 1'b0;
         tx_start    <= 1'b0;
         tx_data     <= 8'h00;
         timeout_err <= 1'b0;
         pkt_count   <= 16'h0000;
      end else begin
         state       <= state_nxt;
         grant       <= grant_nxt;
         rr_ptr      <= rr_ptr_nxt;
         hold_cnt    <= hold_cnt_nxt;
         last_flag   <= last_flag_nxt;
         tx_start    <= tx_start_nxt;
         tx_data     <= tx_data_nxt;
         timeout_err <= timeout_err_nxt;
         pkt_count   <= pkt_count_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: arbitration vector table, scoreboard on tx_start,
// and directed sequences for lock, back-pressure, timeout and mid-packet reset.
module tb_uart_tx_arbiter;

   localparam int NREQ     = 4;
   localparam int HOLD     = 8;
   localparam int BUDGET   = 60;
   localparam int TX_DELAY = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic        tx_done;
   logic [3:0]  grant;
   logic        timeout_err;
   logic [15:0] pkt_count;

   logic model_busy;
   logic bp_force;
   assign tx_busy = model_busy | bp_force;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(NREQ), .HOLD_TIMEOUT(HOLD)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
      .grant(grant), .timeout_err(timeout_err), .pkt_count(pkt_count)
   );

   typedef struct { logic [1:0] owner; logic [7:0] data; } sb_t;
   typedef struct { logic [3:0] mask; logic [1:0] win; } vec_t;

   sb_t  sb_q[$];
   vec_t vecs[10];

   int   checks = 0;
   int   failures = 0;
   int   exp_pkt = 0;
   int   lock_viol = 0;
   logic lock_watch = 1'b0;

   function automatic logic [3:0] onehot(input logic [1:0] i);
      return 4'b0001 << i;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_grant"},       32'(grant),       32'd0);
      chk({tag, "_req_ready"},   32'(req_ready),   32'd0);
      chk({tag, "_tx_start"},    32'(tx_start),    32'd0);
      chk({tag, "_tx_data"},     32'(tx_data),     32'd0);
      chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
      chk({tag, "_pkt_count"},   32'(pkt_count),   32'd0);
   endtask

   task automatic wait_pkt();
      int n = 0;
      @(negedge clk);
      while (pkt_count !== 16'(exp_pkt) && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      chk("pkt_count", 32'(pkt_count), 32'(16'(exp_pkt)));
   endtask

   task automatic wait_grant(input logic [3:0] exp);
      int n = 0;
      @(negedge clk);
      while (grant !== exp && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      chk("grant_wait", 32'(grant), 32'(exp));
   endtask

   // Present one byte from requester r and wait for its handshake.
   task automatic xfer(input logic [1:0] r, input logic [7:0] b, input logic l);
      int n = 0;
      step();
      req_valid[r]       = 1'b1;
      req_data[8*r +: 8] = b;
      req_last[r]        = l;
      @(negedge clk);
      while (req_ready[r] !== 1'b1 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      chk("handshake", 32'(req_ready[r]), 32'd1);
      if (req_ready[r] === 1'b1) begin
         chk("owner_grant", 32'(grant), 32'(onehot(r)));
         sb_q.push_back('{owner: r, data: b});
      end
      step();
      req_valid[r] = 1'b0;
   endtask

   // One-byte packets from every requester in mask; exp_idx must win.
   task automatic arb_pkt(input logic [3:0] mask, input logic [1:0] exp_idx, input logic [7:0] base);
      int n = 0;
      step();
      req_valid = mask;
      req_last  = 4'b1111;
      for (int i = 0; i < 4; i++) req_data[8*i +: 8] = base + 8'(i);
      @(negedge clk);
      while (req_ready === 4'b0000 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      chk("arb_winner", 32'(req_ready), 32'(onehot(exp_idx)));
      if (req_ready !== 4'b0000) sb_q.push_back('{owner: exp_idx, data: base + 8'(exp_idx)});
      step();
      req_valid = 4'b0000;
      exp_pkt++;
      wait_pkt();
   endtask

   // Transmitter model: busy for TX_DELAY cycles after each start, then one done pulse.
   initial begin : tx_model
      int cnt;
      cnt = 0;
      tx_done = 1'b0;
      model_busy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tx_done = 1'b0;
         if (tx_start === 1'b1) begin
            model_busy = 1'b1;
            cnt = TX_DELAY;
         end else if (model_busy) begin
            cnt--;
            if (cnt == 0) begin
               model_busy = 1'b0;
               tx_done = 1'b1;
            end
         end
      end
   end

   initial begin : monitor
      sb_t e;
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_tx_start: tx_data=0x%0h grant=0x%0h at %0t", tx_data, grant, $time);
            end else begin
               e = sb_q.pop_front();
               chk("sb_tx_data", 32'(tx_data), 32'(e.data));
               chk("sb_tx_grant", 32'(grant), 32'(onehot(e.owner)));
            end
         end
         if (lock_watch && req_ready[0] === 1'b1) lock_viol++;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int n;
      vecs[0] = '{4'b1111, 2'd0};
      vecs[1] = '{4'b1111, 2'd1};
      vecs[2] = '{4'b1111, 2'd2};
      vecs[3] = '{4'b1111, 2'd3};
      vecs[4] = '{4'b1111, 2'd0};
      vecs[5] = '{4'b1001, 2'd3};
      vecs[6] = '{4'b0110, 2'd1};
      vecs[7] = '{4'b0011, 2'd0};
      vecs[8] = '{4'b1000, 2'd3};
      vecs[9] = '{4'b0100, 2'd2};

      rst = 1'b1;
      req_valid = '0;
      req_data = '0;
      req_last = '0;
      bp_force = 1'b0;
      step();
      step();
      step();
      @(negedge clk);
      chk_reset("reset");
      step();
      rst = 1'b0;

      // Round robin from reset, then mixed masks.
      for (int k = 0; k < 10; k++) arb_pkt(vecs[k].mask, vecs[k].win, 8'(16 * (k + 1)));

      // Single requester, three-byte packet.
      xfer(2'd2, 8'h41, 1'b0);
      xfer(2'd2, 8'h42, 1'b0);
      xfer(2'd2, 8'h43, 1'b1);
      exp_pkt++;
      wait_pkt();
      chk("single_grant_released", 32'(grant), 32'd0);

      // Packet lock: requester 0 waits while requester 1 finishes its packet.
      xfer(2'd1, 8'h51, 1'b0);
      step();
      req_valid[0] = 1'b1;
      req_data[7:0] = 8'h99;
      req_last[0] = 1'b1;
      lock_watch = 1'b1;
      xfer(2'd1, 8'h52, 1'b1);
      exp_pkt++;
      wait_pkt();
      lock_watch = 1'b0;
      chk("lock_ready0_low", 32'(lock_viol), 32'd0);
      wait_grant(4'b0001);
      chk("lock_next_ready", 32'(req_ready), 32'(4'b0001));
      sb_q.push_back('{owner: 2'd0, data: 8'h99});
      step();
      req_valid[0] = 1'b0;
      exp_pkt++;
      wait_pkt();

      // Back-pressure: tx_busy held high for the first five SEND cycles.
      step();
      bp_force = 1'b1;
      req_valid[2] = 1'b1;
      req_data[23:16] = 8'h77;
      req_last[2] = 1'b1;
      wait_grant(4'b0100);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         chk("bp_ready_low", 32'(req_ready), 32'd0);
      end
      step();
      bp_force = 1'b0;
      @(negedge clk);
      chk("bp_ready_on_fall", 32'(req_ready), 32'(4'b0100));
      sb_q.push_back('{owner: 2'd2, data: 8'h77});
      step();
      req_valid[2] = 1'b0;
      exp_pkt++;
      wait_pkt();

      // Timeout: requester 3 sends a non-last byte then goes quiet.
      xfer(2'd3, 8'hA5, 1'b0);
      n = 0;
      @(negedge clk);
      while (tx_done !== 1'b1 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      chk("to_done_seen", 32'(tx_done), 32'd1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (timeout_err !== 1'b1 && n < 20);
      chk("to_latency", 32'(n), 32'd9);
      chk("to_grant_cleared", 32'(grant), 32'd0);
      chk("to_pkt_unchanged", 32'(pkt_count), 32'(16'(exp_pkt)));
      @(negedge clk);
      chk("to_pulse_width", 32'(timeout_err), 32'd0);
      arb_pkt(4'b1111, 2'd0, 8'hE0);

      // Reset while waiting on the transmitter.
      xfer(2'd3, 8'hC3, 1'b0);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk_reset("midreset");
      exp_pkt = 0;
      n = 0;
      while (tx_done !== 1'b1 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      chk("late_done_seen", 32'(tx_done), 32'd1);
      @(negedge clk);
      chk("late_done_grant", 32'(grant), 32'd0);
      chk("late_done_pkt", 32'(pkt_count), 32'd0);
      arb_pkt(4'b1111, 2'd0, 8'hF0);

      step();
      step();
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
